// File: rtl/debounce.sv
// debounce: 2-FF synchronised, counter-qualified debouncer for one bouncing input.
// Define DEBOUNCE_EDGE_EN to add one-cycle out_rise/out_fall pulses on out transitions.
module debounce #(
    parameter int  C_CLK_FRQ  = 100000000,
    parameter real C_INTERVAL = 10.0
) (
    input  logic clk,
    input  logic rstb,
    input  logic in,
`ifdef DEBOUNCE_EDGE_EN
    output logic out_rise,
    output logic out_fall,
`endif
    output logic out
);
    localparam int C_RAW = int'(real'(C_CLK_FRQ) * C_INTERVAL / 1000.0);
    localparam int C_N = (C_RAW < 1) ? 1 : C_RAW;
    localparam int C_W = $clog2(C_N + 1);
    localparam logic [C_W-1:0] C_LAST = C_W'(C_N - 1);
    logic s1_q, s2_q, out_q, out_d;
    logic [C_W-1:0] cnt_q, cnt_d;
    // Any cycle with s2 back at the output level restarts the interval.
    always_comb begin
        out_d = (s2_q != out_q && cnt_q == C_LAST) ? s2_q : out_q;
        cnt_d = (s2_q == out_q || cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            s1_q  <= in;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end
    assign out = out_q;
`ifdef DEBOUNCE_EDGE_EN
    logic out_dly_q;
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) out_dly_q <= 1'b0;
        else       out_dly_q <= out_q;
    end
    assign out_rise = out_q & ~out_dly_q;
    assign out_fall = ~out_q & out_dly_q;
`endif
endmodule

// File: tb/tb_debounce.sv
// tb_debounce: segment-table bench for debounce with C_N = 1000 cycles (10 us at 100 MHz).
module tb_debounce;
    typedef struct {
        logic  in_v;
        int    cycles;
        logic  exp_out;
        int    exp_tog;
        int    exp_lat;
        string name;
    } vec_t;

    logic clk = 1'b0, rstb = 1'b0, in = 1'bx, out;
`ifdef DEBOUNCE_EDGE_EN
    logic out_rise, out_fall;
`endif
    int tests = 0, fails = 0;
    int cyc = 0, tog = 0, rises = 0, falls = 0, last_chg = 0;
    logic prev_out = 1'b0;
    vec_t tbl[$];
    vec_t exp_q[$];

    debounce #(.C_CLK_FRQ(100000000), .C_INTERVAL(0.010)) dut (
        .clk(clk),
        .rstb(rstb),
        .in(in),
`ifdef DEBOUNCE_EDGE_EN
        .out_rise(out_rise),
        .out_fall(out_fall),
`endif
        .out(out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out !== prev_out) begin
            tog++;
            last_chg = cyc;
        end
        prev_out = out;
`ifdef DEBOUNCE_EDGE_EN
        if (out_rise === 1'b1) rises++;
        if (out_fall === 1'b1) falls++;
`endif
    end

    task automatic check(input string nm, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic check_out(input string nm, input logic exp);
        tests++;
        if (out !== exp) begin
            fails++;
            $display("FAIL %s: out=%b, expected %b", nm, out, exp);
        end
    endtask

    task automatic run_seg(input vec_t v);
        int s_tog, s_rise, s_fall, s_cyc;
        vec_t e;
        @(negedge clk); #1;
        in = v.in_v;
        exp_q.push_back(v);
        s_tog = tog; s_rise = rises; s_fall = falls; s_cyc = cyc;
        repeat (v.cycles) @(negedge clk);
        #1;
        e = exp_q.pop_front();
        check_out({e.name, "_out"}, e.exp_out);
        check({e.name, "_toggles"}, tog - s_tog, e.exp_tog, e.exp_tog);
        if (e.exp_lat > 0)
            check({e.name, "_latency"}, last_chg - s_cyc, e.exp_lat - 1, e.exp_lat + 1);
`ifdef DEBOUNCE_EDGE_EN
        check({e.name, "_rise"}, rises - s_rise, e.exp_out ? e.exp_tog : 0, e.exp_out ? e.exp_tog : 0);
        check({e.name, "_fall"}, falls - s_fall, e.exp_out ? 0 : e.exp_tog, e.exp_out ? 0 : e.exp_tog);
`endif
    endtask

    initial begin
        int s_rise, s_fall;
        tbl.push_back('{1'b1,   90, 1'b0, 0,    0, "t2_b1"});
        tbl.push_back('{1'b0,   20, 1'b0, 0,    0, "t2_b2"});
        tbl.push_back('{1'b1,  230, 1'b0, 0,    0, "t2_b3"});
        tbl.push_back('{1'b0,  180, 1'b0, 0,    0, "t2_b4"});
        tbl.push_back('{1'b1, 7000, 1'b1, 1, 1002, "t2_high"});
        tbl.push_back('{1'b0,  900, 1'b1, 0,    0, "t3_low9us"});
        tbl.push_back('{1'b1,   20, 1'b1, 0,    0, "t3_back_hi"});
        tbl.push_back('{1'b0,  900, 1'b1, 0,    0, "t3_low9us_again"});
        tbl.push_back('{1'b1,  200, 1'b1, 0,    0, "t3_hi"});
        tbl.push_back('{1'b0,   80, 1'b1, 0,    0, "t4_b1"});
        tbl.push_back('{1'b1,   30, 1'b1, 0,    0, "t4_b2"});
        tbl.push_back('{1'b0,   70, 1'b1, 0,    0, "t4_b3"});
        tbl.push_back('{1'b1,   60, 1'b1, 0,    0, "t4_b4"});
        tbl.push_back('{1'b0, 6000, 1'b0, 1, 1002, "t4_low"});
        tbl.push_back('{1'b1,  200, 1'b0, 0,    0, "t5_pulse"});
        tbl.push_back('{1'b0,  500, 1'b0, 0,    0, "t5_after"});
        tbl.push_back('{1'b1, 1100, 1'b1, 1, 1002, "t6_set_hi"});

        // Reset with X then 0 on the pin.
        repeat (10) @(negedge clk);
        check_out("t1_rst_x", 1'b0);
        in = 1'b0;
        repeat (10) @(negedge clk);
        check_out("t1_rst_0", 1'b0);
        #1 rstb = 1'b1;
        repeat (30) @(negedge clk);
        check_out("t1_released", 1'b0);
        check("t1_toggles", tog, 0, 0);
`ifdef DEBOUNCE_EDGE_EN
        check("t1_pulses", rises + falls, 0, 0);
`endif

        foreach (tbl[i]) run_seg(tbl[i]);

        // Reset while out=1 and a fall is being counted.
        @(negedge clk); #1 in = 1'b0;
        repeat (500) @(negedge clk);
        s_rise = rises; s_fall = falls;
        #3 rstb = 1'b0;
        #1 check_out("t6_async_clr", 1'b0);
        repeat (5) @(negedge clk);
        #1 rstb = 1'b1;
        repeat (20) @(negedge clk);
        check_out("t6_after_rel", 1'b0);
`ifdef DEBOUNCE_EDGE_EN
        check("t6_no_pulse", (rises - s_rise) + (falls - s_fall), 0, 0);
`endif

        // A rising count interrupted by reset must restart from zero.
        s_rise = rises;
        #1 in = 1'b1;
        repeat (600) @(negedge clk);
        #1 rstb = 1'b0;
        repeat (2) @(negedge clk);
        #1 rstb = 1'b1;
        repeat (600) @(negedge clk);
        check_out("t6_discard", 1'b0);
        repeat (500) @(negedge clk);
        check_out("t6_restart", 1'b1);
`ifdef DEBOUNCE_EDGE_EN
        check("t6_restart_rise", rises - s_rise, 1, 1);
`endif
        check("t6_queue_empty", exp_q.size(), 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
